weight_stream_loader: RTL and testbench

- Parametrised successor to the per-layer weight loaders.
- Reads a runtime-selected block of weights (base address, word count) from an external read-only BRAM port with configurable read latency.
- Packs the words into LANES-wide beats on a valid/ready stream with backpressure, instead of one flat full-layer register.
- Sits between the shared weight BRAM and the MAC array input. One instance serves any layer.

---
 rtl/weight_stream_loader_if.sv | 25 ++
 rtl/weight_stream_loader.sv | 196 +++++++++++++++++++
 tb/tb_weight_stream_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/weight_stream_loader_if.sv
// Weight loader bus bundle: BRAM read port plus the packed-beat valid/ready output stream.
interface weight_stream_loader_if #(
  parameter int W          = 8,
  parameter int LANES      = 8,
  parameter int ADDR_WIDTH = 18
);
  logic                  bram_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [W-1:0]          bram_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*W-1:0]    out_data;
  logic [LANES-1:0]      out_keep;
  logic                  out_last;

  modport master (
    output bram_en, bram_addr, out_valid, out_data, out_keep, out_last,
    input  bram_dout, out_ready
  );

  modport slave (
    input  bram_en, bram_addr, out_valid, out_data, out_keep, out_last,
    output bram_dout, out_ready
  );
endinterface

// File: rtl/weight_stream_loader.sv
// Streams a block of BRAM weights into LANES-wide beats; reads issue the cycle after start, a beat holds stable under out_ready=0.
// WEIGHT_LOADER_CHECKSUM_EN adds a 16-bit running sum of the words read in the current transfer.
module weight_stream_loader #(
  parameter int W          = 8,
  parameter int LANES      = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int CNT_WIDTH  = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  output logic [15:0]           checksum,
`endif
  weight_stream_loader_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(LANES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CNT_WIDTH-1:0]  issue_left;
  logic [CNT_WIDTH-1:0]  pack_left;
  logic                  bram_en_q;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [RD_LAT-1:0]     rd_pipe;

  logic [W-1:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [W-1:0]          fifo_dat;

  logic [LANES-1:0][W-1:0] lanes_q, lanes_n;
  logic [IW-1:0]         idx_q, idx_n, used;
  logic                  out_valid_q, valid_n;
  logic [LANES-1:0]      keep_q, keep_n;
  logic                  last_q, last_n;

  logic                  start_ok;
  logic                  issue;
  logic                  accept;
  logic [CW-1:0]         inflight;
  logic [CW:0]           occ;

  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign accept   = out_valid_q && bus.out_ready;

  // Reads already issued but not yet landed in the FIFO, including the one on the bus now.
  always_comb begin
    inflight = CW'(bram_en_q);
    for (int k = 0; k < RD_LAT; k++) begin
      inflight = inflight + CW'(rd_pipe[k]);
    end
  end

  assign occ   = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue = (state == S_RUN) && (issue_left != '0) &&
                 (occ < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_addr     <= '0;
      issue_left  <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      rd_pipe     <= '0;
    end else begin
      bram_en_q  <= issue;
      rd_pipe[0] <= bram_en_q;
      for (int k = 1; k < RD_LAT; k++) begin
        rd_pipe[k] <= rd_pipe[k-1];
      end
      if (issue) begin
        bram_addr_q <= rd_addr;
        rd_addr     <= rd_addr + ADDR_WIDTH'(1);
        issue_left  <= issue_left - CNT_WIDTH'(1);
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rd_addr    <= base_addr;
            issue_left <= num_words;
            state      <= (num_words == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue && (issue_left == CNT_WIDTH'(1))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (accept && last_q) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Word FIFO: data returning from the BRAM lands here, the packer drains it.
  assign fifo_push = rd_pipe[RD_LAT-1];
  assign fifo_dat  = fifo_mem[rd_ptr];
  assign fifo_pop  = (fifo_count != '0) && (!out_valid_q || bus.out_ready) &&
                     (pack_left != '0);

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= bus.bram_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (fifo_push && !fifo_pop)      fifo_count <= fifo_count + CW'(1);
      else if (!fifo_push && fifo_pop) fifo_count <= fifo_count - CW'(1);
    end
  end

  // Packer: an accepted beat clears the slots so a pop in the same cycle restarts at lane 0.
  always_comb begin
    lanes_n = accept ? '0 : lanes_q;
    idx_n   = accept ? '0 : idx_q;
    valid_n = accept ? 1'b0 : out_valid_q;
    keep_n  = accept ? '0 : keep_q;
    last_n  = accept ? 1'b0 : last_q;
    used    = idx_n + IW'(1);
    if (fifo_pop) begin
      for (int k = 0; k < LANES; k++) begin
        if (IW'(k) == idx_n) lanes_n[k] = fifo_dat;
      end
      if ((used == IW'(LANES)) || (pack_left == CNT_WIDTH'(1))) begin
        valid_n = 1'b1;
        last_n  = (pack_left == CNT_WIDTH'(1));
        for (int k = 0; k < LANES; k++) begin
          keep_n[k] = (IW'(k) < used);
        end
      end
      idx_n = used;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      pack_left   <= '0;
    end else begin
      lanes_q     <= lanes_n;
      idx_q       <= idx_n;
      out_valid_q <= valid_n;
      keep_q      <= keep_n;
      last_q      <= last_n;
      if (start_ok)      pack_left <= num_words;
      else if (fifo_pop) pack_left <= pack_left - CNT_WIDTH'(1);
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            checksum <= '0;
    else if (start_ok)  checksum <= '0;
    else if (fifo_push) checksum <= checksum + 16'(bus.bram_dout);
  end
`endif

  assign bus.bram_en   = bram_en_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = lanes_q;
  assign bus.out_keep  = keep_q;
  assign bus.out_last  = last_q;
  assign busy          = (state == S_RUN) || (state == S_DRAIN);
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_weight_stream_loader.sv
// Scoreboard bench for weight_stream_loader: directed transfers against a mem[i]=i&0xFF BRAM model.
module tb_weight_stream_loader;
  localparam int W = 8, LANES = 8, AW = 18, CNTW = 16, RD_LAT = 2, DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [CNTW-1:0] num_words = '0;
  logic            busy, done;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0]     checksum;
`endif

  weight_stream_loader_if #(.W(W), .LANES(LANES), .ADDR_WIDTH(AW)) bus();

  weight_stream_loader #(
    .W(W), .LANES(LANES), .ADDR_WIDTH(AW), .CNT_WIDTH(CNTW),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Two-cycle BRAM: address sampled at the edge, data visible two cycles after the read cycle.
  logic [7:0] d1 = '0, d2 = '0;
  always @(posedge clk) begin
    d1 <= bus.bram_addr[7:0];
    d2 <= d1;
  end
  assign bus.bram_dout = d2;

  int checks = 0, failures = 0;
  int en_total = 0, vld_total = 0;
  logic [63:0] q_data[$];
  logic [7:0]  q_keep[$];
  logic        q_last[$];
  bit          pend_done = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      if (pend_done) begin
        chk("done_after_last", 64'(done), 64'd1);
        pend_done = 0;
      end
      if (!rst) begin
        if (bus.bram_en)   en_total++;
        if (bus.out_valid) vld_total++;
        if (bus.out_valid && bus.out_ready) begin
          chk("beat_expected", 64'(q_data.size() != 0), 64'd1);
          if (q_data.size() != 0) begin
            chk("beat_data", bus.out_data, q_data.pop_front());
            chk("beat_keep", 64'(bus.out_keep), 64'(q_keep.pop_front()));
            chk("beat_last", 64'(bus.out_last), 64'(q_last.pop_front()));
          end
          if (bus.out_last) pend_done = 1;
        end
      end
    end
  end

  task automatic push_exp(int base, int n);
    int nb;
    nb = (n + LANES - 1) / LANES;
    for (int b = 0; b < nb; b++) begin
      logic [63:0] d;
      logic [7:0]  k;
      d = '0;
      k = '0;
      for (int l = 0; l < LANES; l++) begin
        int i;
        i = b * LANES + l;
        if (i < n) begin
          d[l*8 +: 8] = 8'((base + i) & 255);
          k[l] = 1'b1;
        end
      end
      q_data.push_back(d);
      q_keep.push_back(k);
      q_last.push_back(b == nb - 1);
    end
  endtask

  task automatic do_start(int base, int n);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(base);
    num_words = CNTW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!done && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("xfer_done", 64'(done), 64'd1);
  endtask

  task automatic chk_outputs_zero(string tag);
    chk({tag, "_bram_en"},   64'(bus.bram_en), 64'd0);
    chk({tag, "_bram_addr"}, 64'(bus.bram_addr), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_data"},  bus.out_data, 64'd0);
    chk({tag, "_out_keep"},  64'(bus.out_keep), 64'd0);
    chk({tag, "_out_last"},  64'(bus.out_last), 64'd0);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_done"},      64'(done), 64'd0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"},  64'(checksum), 64'd0);
`endif
  endtask

  initial begin
    int e0, v0, c;
    bus.out_ready = 1'b1;
    #1;
    chk_outputs_zero("rst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Two full beats
    e0 = en_total;
    push_exp(100, 16);
    do_start(100, 16);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done();
    chk("t1_reads", 64'(en_total - e0), 64'd16);
    chk("t1_queue", 64'(q_data.size()), 64'd0);

    // Partial final beat
    e0 = en_total;
    push_exp(100, 10);
    do_start(100, 10);
    wait_done();
    chk("t2_reads", 64'(en_total - e0), 64'd10);
    chk("t2_queue", 64'(q_data.size()), 64'd0);

    // Backpressure: first beat held 40 cycles
    e0 = en_total;
    bus.out_ready = 1'b0;
    push_exp(0, 64);
    do_start(0, 64);
    c = 0;
    while (!bus.out_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("t3_first_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("t3_stall_data", bus.out_data, 64'h0706050403020100);
      chk("t3_stall_valid", 64'(bus.out_valid), 64'd1);
    end
    chk("t3_stall_reads", 64'(en_total - e0), 64'd24);
    bus.out_ready = 1'b1;
    wait_done();
    chk("t3_reads", 64'(en_total - e0), 64'd64);
    chk("t3_queue", 64'(q_data.size()), 64'd0);

    // Address wrap
    e0 = en_total;
    push_exp(262141, 8);
    do_start(262141, 8);
    wait_done();
    chk("t4_reads", 64'(en_total - e0), 64'd8);
    chk("t4_queue", 64'(q_data.size()), 64'd0);

    // Reset mid-transfer
    e0 = en_total;
    do_start(0, 32);
    c = 0;
    while ((en_total - e0) < 5 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    chk("t6_reads_before_rst", 64'((en_total - e0) >= 5), 64'd1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-length transfer from IDLE
    chk("t5_done_pre", 64'(done), 64'd0);
    e0 = en_total;
    v0 = vld_total;
    do_start(0, 0);
    chk("t5_done", 64'(done), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_reads", 64'(en_total - e0), 64'd0);
    chk("t5_valids", 64'(vld_total - v0), 64'd0);

    // Fresh transfer after reset: no stale words
    e0 = en_total;
    push_exp(0, 8);
    do_start(0, 8);
    wait_done();
    chk("t6_reads", 64'(en_total - e0), 64'd8);
    chk("t6_queue", 64'(q_data.size()), 64'd0);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    push_exp(0, 16);
    do_start(0, 16);
    wait_done();
    chk("checksum", 64'(checksum), 64'd120);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
